// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU MEM stage and a word-addressed req/ack data bus.
// Checks alignment, drives byte enables and lane-replicated store data, and extends load data.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_exc,
  output logic [1:0]  cpu_exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_ADEL    = 2'd1;
  localparam logic [1:0] EXC_ADES    = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT = 2'd3;
  localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        exc_q, exc_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] rdata_q, rdata_d;

  // Request decode: size 3 behaves exactly like a word access.
  logic        req_half, req_byte, req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  always_comb begin
    req_half       = (cpu_size == 2'd1);
    req_byte       = (cpu_size == 2'd2);
    req_misaligned = 1'b0;
    req_be         = 4'b1111;
    req_wdata      = cpu_wdata;
    if (req_byte) begin
      req_be    = 4'b0001 << cpu_addr[1:0];
      req_wdata = {4{cpu_wdata[7:0]}};
    end else if (req_half) begin
      req_be         = cpu_addr[1] ? 4'b1100 : 4'b0011;
      req_wdata      = {2{cpu_wdata[15:0]}};
      req_misaligned = cpu_addr[0];
    end else begin
      req_misaligned = (cpu_addr[1:0] != 2'b00);
    end
  end

  // Load extraction from the returned word, steered by the captured size/lane.
  logic [7:0]  rd_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = rd_lane[lane_q];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd1:    load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      2'd2:    load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    code_d  = code_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_valid) begin
          we_d   = cpu_we;
          size_d = cpu_size;
          uns_d  = cpu_unsigned;
          lane_d = cpu_addr[1:0];
          cnt_d  = 8'd0;
          if (req_misaligned) begin
            // Faulted requests leave the bus fields untouched: no traffic at all.
            exc_d   = 1'b1;
            code_d  = cpu_we ? EXC_ADES : EXC_ADEL;
            state_d = ST_DONE;
          end else begin
            addr_d  = {cpu_addr[31:2], 2'b00};
            be_d    = req_be;
            wdata_d = req_wdata;
            exc_d   = 1'b0;
            code_d  = EXC_NONE;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Ack wins over timeout when both land in the last counted cycle.
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = load_ext;
          end
          cnt_d   = 8'd0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          exc_d   = 1'b1;
          code_d  = EXC_TIMEOUT;
          cnt_d   = 8'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        exc_d   = 1'b0;
        code_d  = EXC_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      lane_q  <= 2'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 8'd0;
      exc_q   <= 1'b0;
      code_q  <= EXC_NONE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign cpu_done     = (state_q == ST_DONE);
  assign cpu_exc      = cpu_done & exc_q;
  assign cpu_exc_code = cpu_done ? code_q : EXC_NONE;
  assign cpu_rdata    = rdata_q;
  assign mem_req      = (state_q == ST_REQ);
  // Store flag only reaches the bus once a request has been issued.
  assign mem_we       = we_q & (be_q != 4'd0);
  assign mem_addr     = addr_q;
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;

endmodule
